// File: rtl/cva5_types.sv
// Shared TLB types: access classes, entry layout, requester states.
// Imported by the TLB walk requester and its helpers.
package cva5_types;

    localparam int TLB_ASID_W = 9;

    typedef enum logic [1:0] {
        CLS_STORE = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_FETCH = 2'd2
    } access_class_t;

    typedef struct packed {
        logic                  valid;
        logic [19:0]           vpn;
        logic [TLB_ASID_W-1:0] asid;
        access_class_t         cls;
        logic [19:0]           ppn;
    } tlb_entry_t;

    typedef enum logic [3:0] {
        TLB_IDLE    = 4'b0001,
        TLB_LOOKUP  = 4'b0010,
        TLB_MISS    = 4'b0100,
        TLB_RESPOND = 4'b1000
    } tlb_state_t;

    function automatic access_class_t get_class(
        input logic rnw,
        input logic execute
    );
        if (execute)
            return CLS_FETCH;
        else if (rnw)
            return CLS_LOAD;
        else
            return CLS_STORE;
    endfunction

endpackage

// File: rtl/tlb_replace_ptr.sv
// One-hot round-robin victim pointer for the TLB.
// Advances one way per fill and wraps back to way 0.
module tlb_replace_ptr #(
    parameter int WAYS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_advance,
    output logic [WAYS-1:0] o_ptr
);

    logic [WAYS-1:0] r_ptr;

    // Rotate the one-hot pointer left on every fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= WAYS'(1);
        else if (i_advance)
            r_ptr <= {r_ptr[WAYS-2:0], r_ptr[WAYS-1]};
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/tlb_walk_requester.sv
// Fully-associative Sv32 TLB that requests page walks from the MMU
// on a miss, installs fills round-robin and returns the physical address.
module tlb_walk_requester
    import cva5_types::*;
#(
    parameter int WAYS   = 4,
    parameter int ASID_W = TLB_ASID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tlb_on,
    input  logic [ASID_W-1:0] asid,
    input  logic              flush,
    input  logic              abort_request,
    input  logic              new_request,
    input  logic [31:0]       virtual_address,
    input  logic              rnw,
    input  logic              execute,
    output logic              ready,
    output logic              done,
    output logic              is_fault,
    output logic [31:0]       physical_address,
    output logic              mmu_request,
    output logic [31:0]       mmu_virtual_address,
    output logic              mmu_rnw,
    output logic              mmu_execute,
    input  logic [19:0]       mmu_upper_physical_address,
    input  logic              mmu_write_entry,
    input  logic              mmu_is_fault
);

    tlb_state_t        r_state;
    tlb_state_t        w_next;
    tlb_entry_t        r_tlb [WAYS];
    tlb_entry_t        w_fill;
    logic [31:0]       r_va;
    logic [31:0]       r_pa;
    logic              r_rnw;
    logic              r_exec;
    logic              r_fault;
    logic [ASID_W-1:0] r_asid;
    logic              w_accept;
    logic              w_install;
    logic              w_any_hit;
    logic [WAYS-1:0]   w_hit;
    logic [WAYS-1:0]   w_ptr;
    logic [19:0]       w_ppn_way [WAYS];
    logic [19:0]       w_hit_ppn;
    access_class_t     w_cls;

    assign w_accept = new_request & ready;
    assign w_cls    = get_class(rnw, execute);

    // Tag compare against the incoming request, one-hot per way
    for (genvar i = 0; i < WAYS; i++) begin : g_way
        assign w_hit[i] = r_tlb[i].valid
                        & (r_tlb[i].vpn  == virtual_address[31:12])
                        & (r_tlb[i].asid == asid)
                        & (r_tlb[i].cls  == w_cls);
        assign w_ppn_way[i] = r_tlb[i].ppn & {20{w_hit[i]}};
    end

    // OR-reduce the masked PPNs; at most one way contributes
    always_comb begin
        w_hit_ppn = '0;
        for (int i = 0; i < WAYS; i++)
            w_hit_ppn = w_hit_ppn | w_ppn_way[i];
    end

    assign w_any_hit = |w_hit;

    assign w_fill = '{
        valid: 1'b1,
        vpn:   r_va[31:12],
        asid:  r_asid,
        cls:   get_class(r_rnw, r_exec),
        ppn:   mmu_upper_physical_address
    };

    tlb_replace_ptr #(.WAYS(WAYS)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_install),
        .o_ptr     (w_ptr)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= TLB_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and handshake outputs; abort masks everything
    always_comb begin
        w_next      = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        mmu_request = 1'b0;
        w_install   = 1'b0;
        case (r_state)
            TLB_IDLE: begin
                ready = ~flush;
                if (w_accept)
                    w_next = (~tlb_on | w_any_hit) ? TLB_LOOKUP : TLB_MISS;
            end
            TLB_LOOKUP: begin
                done   = 1'b1;
                w_next = TLB_IDLE;
            end
            TLB_MISS: begin
                mmu_request = 1'b1;
                if (mmu_write_entry) begin
                    w_install = 1'b1;
                    w_next    = TLB_RESPOND;
                end else if (mmu_is_fault) begin
                    w_next = TLB_RESPOND;
                end
            end
            TLB_RESPOND: begin
                done   = 1'b1;
                w_next = TLB_IDLE;
            end
            default: w_next = TLB_IDLE;
        endcase
        if (abort_request) begin
            w_next      = TLB_IDLE;
            done        = 1'b0;
            mmu_request = 1'b0;
            w_install   = 1'b0;
        end
        is_fault = done & r_fault;
    end

    // Request latch and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_va    <= '0;
            r_pa    <= '0;
            r_rnw   <= 1'b0;
            r_exec  <= 1'b0;
            r_asid  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_va    <= virtual_address;
                r_rnw   <= rnw;
                r_exec  <= execute;
                r_asid  <= asid;
                r_fault <= 1'b0;
                r_pa    <= tlb_on ? {w_hit_ppn, virtual_address[11:0]}
                                  : virtual_address;
            end
            if (r_state == TLB_MISS) begin
                if (mmu_write_entry) begin
                    r_pa    <= {mmu_upper_physical_address, r_va[11:0]};
                    r_fault <= 1'b0;
                end else if (mmu_is_fault) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    // Entry storage: flush clears valids, a same-cycle fill still lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++)
                r_tlb[i] <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (flush)
                    r_tlb[i].valid <= 1'b0;
                if (w_install & w_ptr[i])
                    r_tlb[i] <= w_fill;
            end
        end
    end

    assign physical_address    = r_pa;
    assign mmu_virtual_address = r_va;
    assign mmu_rnw             = r_rnw;
    assign mmu_execute         = r_exec;

    a_one_hit: assert property (
        @(posedge clk) disable iff (rst) $onehot0(w_hit)
    );

    a_req_in_miss: assert property (
        @(posedge clk) disable iff (rst) mmu_request |-> (r_state == TLB_MISS)
    );

endmodule

// File: tb/tb_tlb_walk_requester.sv
// Scoreboard bench for tlb_walk_requester: expected results are queued
// when a request is driven and compared when done pulses.
module tb_tlb_walk_requester;

    logic        clk;
    logic        rst;
    logic        tlb_on;
    logic [8:0]  asid;
    logic        flush;
    logic        abort_request;
    logic        new_request;
    logic [31:0] virtual_address;
    logic        rnw;
    logic        execute;
    logic        ready;
    logic        done;
    logic        is_fault;
    logic [31:0] physical_address;
    logic        mmu_request;
    logic [31:0] mmu_virtual_address;
    logic        mmu_rnw;
    logic        mmu_execute;
    logic [19:0] mmu_upper_physical_address;
    logic        mmu_write_entry;
    logic        mmu_is_fault;

    typedef struct packed {
        logic        fault;
        logic [31:0] pa;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int   n_checks = 0;
    int   n_errors = 0;

    tlb_walk_requester #(.WAYS(4), .ASID_W(9)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .tlb_on                     (tlb_on),
        .asid                       (asid),
        .flush                      (flush),
        .abort_request              (abort_request),
        .new_request                (new_request),
        .virtual_address            (virtual_address),
        .rnw                        (rnw),
        .execute                    (execute),
        .ready                      (ready),
        .done                       (done),
        .is_fault                   (is_fault),
        .physical_address           (physical_address),
        .mmu_request                (mmu_request),
        .mmu_virtual_address        (mmu_virtual_address),
        .mmu_rnw                    (mmu_rnw),
        .mmu_execute                (mmu_execute),
        .mmu_upper_physical_address (mmu_upper_physical_address),
        .mmu_write_entry            (mmu_write_entry),
        .mmu_is_fault               (mmu_is_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard whenever the DUT reports a result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("fault", 64'(is_fault), 64'(sb_e.fault));
                if (!sb_e.fault)
                    chk("pa", 64'(physical_address), 64'(sb_e.pa));
            end
        end
    end

    task automatic accept(
        input logic [31:0] va,
        input logic        r,
        input logic        x
    );
        @(negedge clk);
        chk("ready", 64'(ready), 64'd1);
        virtual_address = va;
        rnw             = r;
        execute         = x;
        new_request     = 1'b1;
        @(posedge clk);
        #1;
        new_request = 1'b0;
    endtask

    task automatic req(
        input logic [31:0] va,
        input logic        r,
        input logic        x,
        input logic        miss,
        input logic        fault,
        input logic [19:0] ppn
    );
        logic [31:0] pa;
        pa = tlb_on ? {ppn, va[11:0]} : va;
        sb.push_back('{fault: fault, pa: pa});
        accept(va, r, x);
        chk("req_after_accept", 64'(mmu_request), 64'(miss));
        if (!miss) begin
            chk("hit_latency", 64'(done), 64'd1);
            @(posedge clk);
            #1;
        end else begin
            repeat (2) begin
                @(negedge clk);
                chk("req_held", 64'(mmu_request), 64'd1);
                chk("va_held", 64'(mmu_virtual_address), 64'(va));
                chk("rnw_held", 64'(mmu_rnw), 64'(r));
                chk("exec_held", 64'(mmu_execute), 64'(x));
                chk("done_early", 64'(done), 64'd0);
            end
            @(negedge clk);
            mmu_upper_physical_address = ppn;
            if (fault)
                mmu_is_fault = 1'b1;
            else
                mmu_write_entry = 1'b1;
            @(posedge clk);
            #1;
            mmu_write_entry = 1'b0;
            mmu_is_fault    = 1'b0;
            chk("miss_latency", 64'(done), 64'd1);
            chk("req_drop", 64'(mmu_request), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst                        = 1'b1;
        tlb_on                     = 1'b1;
        asid                       = 9'h005;
        flush                      = 1'b0;
        abort_request              = 1'b0;
        new_request                = 1'b0;
        virtual_address            = '0;
        rnw                        = 1'b0;
        execute                    = 1'b0;
        mmu_upper_physical_address = '0;
        mmu_write_entry            = 1'b0;
        mmu_is_fault               = 1'b0;

        #23;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(is_fault), 64'd0);
        chk("rst_mmu_req", 64'(mmu_request), 64'd0);
        chk("rst_pa", 64'(physical_address), 64'd0);
        chk("rst_va", 64'(mmu_virtual_address), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, hit, class mismatch
        req(32'h4000_1234, 1'b1, 1'b0, 1'b1, 1'b0, 20'h8_0012);
        req(32'h4000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 20'h8_0012);
        req(32'h4000_1234, 1'b0, 1'b0, 1'b1, 1'b0, 20'h8_0077);

        // Fault twice: nothing installed
        req(32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0_0000);
        req(32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0_0000);

        // Abort three cycles into the walk, late response ignored
        accept(32'h5000_0000, 1'b1, 1'b0);
        chk("abort_req_up", 64'(mmu_request), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort_request = 1'b1;
        #1;
        chk("abort_mask", 64'(mmu_request), 64'd0);
        chk("abort_no_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        abort_request = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        @(negedge clk);
        mmu_upper_physical_address = 20'hA_BCDE;
        mmu_write_entry            = 1'b1;
        @(posedge clk);
        #1;
        mmu_write_entry = 1'b0;
        chk("late_no_done", 64'(done), 64'd0);
        chk("late_ready", 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        chk("late_no_done2", 64'(done), 64'd0);
        req(32'h5000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h8_0050);

        // Replacement wrap-around
        do_flush();
        for (int i = 0; i < 5; i++)
            req(32'h1000_0000 + 32'(i) * 32'h1000, 1'b1, 1'b0,
                1'b1, 1'b0, 20'h9_0000 + 20'(i));
        for (int i = 1; i < 5; i++)
            req(32'h1000_0000 + 32'(i) * 32'h1000, 1'b1, 1'b0,
                1'b0, 1'b0, 20'h9_0000 + 20'(i));
        req(32'h1000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h9_0000);

        // Flush invalidates everything; ASID is part of the tag
        do_flush();
        for (int i = 1; i < 5; i++)
            req(32'h1000_0000 + 32'(i) * 32'h1000, 1'b1, 1'b0,
                1'b1, 1'b0, 20'h9_0010 + 20'(i));
        asid = 9'h006;
        req(32'h1000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h9_0020);
        asid = 9'h005;
        req(32'h1000_3000, 1'b1, 1'b0, 1'b0, 1'b0, 20'h9_0013);

        // Bypass
        tlb_on = 1'b0;
        req(32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0_0000);
        tlb_on = 1'b1;

        // Asynchronous reset in the middle of a walk
        accept(32'h2000_0000, 1'b1, 1'b0);
        chk("rst_walk_up", 64'(mmu_request), 64'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_req", 64'(mmu_request), 64'd0);
        chk("rst_async_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        req(32'h1000_3000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h9_0033);
        req(32'h1000_3000, 1'b1, 1'b0, 1'b0, 1'b0, 20'h9_0033);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
